// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Op codes, FSM states and the divide-by-zero quotient.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_hilo_divu_step.sv
// One restoring-division iteration on magnitudes.
// Shifts the next dividend bit in and subtracts when it fits.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // trial subtract; the top bit of diff is the borrow
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_q, sign_d;
  logic             rsign_q, rsign_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_div, op_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             fast_go;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

  // sign/zero-extend then keep the low 2W bits of the product
  always_comb begin
    ext_a = op_sgn ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val}
                   : {{WIDTH{1'b0}}, rs_val};
    ext_b = op_sgn ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val}
                   : {{WIDTH{1'b0}}, rt_val};
    fast_prod = ext_a * ext_b;
    fast_go   = start & ~op_div;
  end
`else
  assign fast_go = 1'b0;
`endif

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (acc_hi_q),
    .bit_i (acc_lo_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // operand decode, magnitudes and final sign correction
  always_comb begin
    op_div   = (op == OP_DIV) || (op == OP_DIVU);
    op_sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_neg    = op_sgn & rs_val[WIDTH-1];
    b_neg    = op_sgn & rt_val[WIDTH-1];
    a_mag    = a_neg ? -rs_val : rs_val;
    b_mag    = b_neg ? -rt_val : rt_val;
    mul_sum  = {1'b0, acc_hi_q}
             + (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = sign_q ? -prod : prod;
    quo_fix  = sign_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = rsign_q ? -acc_hi_q : acc_hi_q;
  end

  // next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    div0_d   = div0_q;
    dvs_d    = dvs_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hi_wen) hi_d = wdata;
        if (lo_wen) lo_d = wdata;
        if (fast_go) begin
`ifdef MULDIV_FAST_MUL_EN
          hi_d   = fast_prod[2*WIDTH-1:WIDTH];
          lo_d   = fast_prod[WIDTH-1:0];
`endif
          done_d = 1'b1;
        end else if (start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          is_div_d = op_div;
          sign_d   = a_neg ^ b_neg;
          rsign_d  = a_neg;
          div0_d   = op_div && (rt_val == '0);
          acc_hi_d = '0;
          acc_lo_d = op_div ? a_mag : b_mag;
          dvs_d    = op_div ? b_mag : a_mag;
        end
      end
      ST_RUN: begin
        if (is_div_q) begin
          acc_hi_d = step_rem;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], step_q};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? WIDTH'(DIV0_QUOT) : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      div0_q   <= 1'b0;
      dvs_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      div0_q   <= div0_d;
      dvs_q    <= dvs_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomized bench for muldiv_hilo against an arithmetic model.
// Honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        res, start, hi_wen, lo_wen;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  muldiv_hilo dut (
    .clk    (clk),
    .res    (res),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_wen (hi_wen),
    .lo_wen (lo_wen),
    .wdata  (wdata),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} from plain arithmetic
  function automatic logic [63:0] ref_calc(
      input logic [1:0] o,
      input logic [31:0] a,
      input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: begin
        u = {32'b0, a} * {32'b0, b};
        return u;
      end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) return 0;
`endif
    return 33;
  endfunction

  // issue one op; optionally poke start/wen mid-run at sample poke
  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int poke);
    int n, bc;
    logic [63:0] e;
    e = ref_calc(o, a, b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    n = 0; bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (n == poke) begin
        start = 1'b1; hi_wen = 1'b1; lo_wen = 1'b1;
        wdata = 32'hDEAD_BEEF;
        op = 2'd1; rs_val = 32'd7; rt_val = 32'd9;
      end else if (n == poke + 1) begin
        start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat(o)));
    chk({tag, "_busy"}, 64'(bc), 64'(exp_lat(o)));
    chk({tag, "_hilo"}, {hi, lo}, e);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    logic [31:0] a, b, w;
    logic [1:0] o;
    res = 1'b1; start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    op = 2'd0; rs_val = '0; rt_val = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd56, -5);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -5);
    run_op("div_small", 2'd2, 32'hFFFF_FFE2, 32'd56, -5);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, -5);
    run_op("divu_by0", 2'd3, 32'd1234, 32'd0, -5);
    run_op("div_by0_neg", 2'd2, 32'hFFFF_FF00, 32'd0, -5);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -5);

    wdata = 32'hA5A5_A5A5; hi_wen = 1'b1;
    @(posedge clk); #1;
    hi_wen = 1'b0;
    chk("mthi", 64'(hi), 64'hA5A5_A5A5);
    wdata = 32'h1234_5678; lo_wen = 1'b1;
    @(posedge clk); #1;
    lo_wen = 1'b0;
    chk("mtlo", 64'(lo), 64'h1234_5678);
    chk("mtlo_hi_kept", 64'(hi), 64'hA5A5_A5A5);

    if (exp_lat(2'd0) > 0)
      run_op("mult_poke", 2'd0, 32'h0001_2345, 32'hFFFF_0003, 5);
    run_op("div_poke", 2'd2, 32'hFFFF_1000, 32'd77, 5);

    op = 2'd2; rs_val = 32'd1000; rt_val = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    if (done) seen++;
    chk("abort_nodone", 64'(seen), 64'd0);
    run_op("divu_9_3", 2'd3, 32'd9, 32'd3, -5);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = rnd_val();
      b = rnd_val();
      w = $urandom;
      wdata = w;
      hi_wen = 1'($urandom_range(0, 1));
      lo_wen = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, -5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the single-issue MIPS datapath.
- Sits directly downstream of the register file: consumes the two read operands (rs into rs_val, rt into rt_val) when the decoder issues MULT/MULTU/DIV/DIVU.
- Exposes HI/LO to the writeback mux for MFHI/MFLO.
- Provides a busy flag that the control unit uses to stall issue.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- res  input  1  reset; synchronous, active-high.
- start  input  1  issue request; sampled on posedge.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  input  WIDTH  multiplicand / dividend.
- rt_val  input  WIDTH  multiplier / divisor.
- hi_wen  input  1  MTHI write enable.
- lo_wen  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO just updated.

Behaviour:
- Reset: res=1 at a posedge forces state=IDLE, hi=0, lo=0, busy=0, done=0 and clears the counter. Reset wins over all other inputs, including mid-operation; the aborted result is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 latches operands and op and clears the counter.
  - For signed ops, latches operand magnitudes plus the result signs: quotient/product sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Transition to RUN.
- RUN:
  - One shift-add (multiply) or restoring-subtract (divide) step per cycle.
  - Counter increments 0..31; at count 31 transition to FIX.
- FIX:
  - Apply two's-complement sign correction and write HI/LO.
  - Pulse done=1 for exactly this one cycle, then transition to IDLE.
- busy=1 in RUN and FIX; 0 in IDLE.
- Latency: start accepted at edge E0 → HI/LO valid and done=1 after edge E0+33. A new start is accepted on the cycle done is high (busy falls at that edge).
- start while busy: ignored; the control unit must hold issue.
- Multiply results: HI = upper word, LO = lower word of the 64-bit product. Signed ops treat operands as two's complement.
- Divide results: LO = quotient, HI = remainder. Truncation toward zero; remainder takes the dividend's sign.
- Divide by zero: LO = 0xFFFFFFFF, HI = rs_val unmodified; same 33-cycle latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- MTHI/MTLO:
  - In IDLE, hi_wen/lo_wen write wdata at the next edge.
  - While busy, both are ignored.
  - start together with hi_wen/lo_wen in IDLE: the write applies and the operation starts; the later result overwrites it.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU are computed with a single-cycle combinational multiplier.
  - HI/LO are written on the accept edge; done pulses in the following cycle; busy stays 0.
  - DIV/DIVU are unchanged (33-cycle path).
- Undefined: all four ops use the iterative 33-cycle path.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state encoding (ST_IDLE, ST_RUN, ST_FIX);
  - DIV0_QUOT = 32'hFFFFFFFF.
- Sub-module divu_step: one combinational restoring-division iteration. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder, quotient bit. Instantiated once, used every RUN cycle.

Test Plan:
- MULT rs=0xFFFFFFFD (−3), rt=56 → after 33 cycles done=1, HI=0xFFFFFFFF, LO=0xFFFFFF58; busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFE2 (−30), rt=56 → LO=0, HI=0xFFFFFFE2. Then DIVU 100/7 → LO=14, HI=2.
- DIVU 1234/0 → LO=0xFFFFFFFF, HI=1234. Then DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0xA5A5A5A5 in IDLE → hi=0xA5A5A5A5 next cycle. Start MULT, then assert lo_wen and start mid-run → both ignored; result unaffected.
- Start DIV, assert res at cycle 10 → next cycle busy=0, hi=lo=0, no done pulse. Fresh DIVU 9/3 completes → LO=3, HI=0.
